pipelined_adder_subtractor: RTL and testbench

PIPELINED_ADDER_SUBTRACTOR -- requirements
Module: pipelined_adder_subtractor

---
 rtl/pipelined_adder_subtractor.sv | 132 +++++++++++++
 tb/tb_pipelined_adder_subtractor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_subtractor.sv
// rtl/pipelined_adder_subtractor.sv - carry-chunked pipelined adder/subtractor with saturation and valid/ready flow control
module pipelined_adder_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Op,
    input  logic             Sat,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             Z,
    output logic             N,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    // Operands travel whole; b is already conditionally inverted for subtract.
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [STAGES-1:0] carry_q, carry_d;
    logic [STAGES-1:0] op_q, op_d;
    logic [STAGES-1:0] sat_q, sat_d;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] en;

    function automatic logic [WIDTH:0] resolve(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] s,
        input logic             cin,
        input int               k
    );
        logic [CHUNK:0]   part;
        logic [WIDTH-1:0] r;
        part = {1'b0, a[k*CHUNK +: CHUNK]} + {1'b0, b[k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, cin};
        r = s;
        r[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
        return {part[CHUNK], r};
    endfunction

    assign in_ready  = ~vld_q[LAST] | out_ready;
    assign out_valid = vld_q[LAST];

    always_comb begin
        logic [WIDTH:0] res;
        logic [WIDTH-1:0] b_inv;
        // A stage may take new contents when it is empty or its successor moves,
        // so bubbles ahead of a stalled output still collapse.
        en[LAST] = ~vld_q[LAST] | out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            en[k] = ~vld_q[k] | en[k+1];
        end

        b_inv      = B ^ {WIDTH{Op}};
        res        = resolve(A, b_inv, '0, Op, 0);
        a_d[0]     = A;
        b_d[0]     = b_inv;
        sum_d[0]   = res[WIDTH-1:0];
        carry_d[0] = res[WIDTH];
        op_d[0]    = Op;
        sat_d[0]   = Sat;
        vld_d[0]   = in_valid & in_ready;

        for (int k = 1; k < STAGES; k++) begin
            res        = resolve(a_q[k-1], b_q[k-1], sum_q[k-1], carry_q[k-1], k);
            a_d[k]     = a_q[k-1];
            b_d[k]     = b_q[k-1];
            sum_d[k]   = res[WIDTH-1:0];
            carry_d[k] = res[WIDTH];
            op_d[k]    = op_q[k-1];
            sat_d[k]   = sat_q[k-1];
            vld_d[k]   = vld_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
            carry_q <= '0;
            op_q    <= '0;
            sat_q   <= '0;
            vld_q   <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    a_q[k]     <= a_d[k];
                    b_q[k]     <= b_d[k];
                    sum_q[k]   <= sum_d[k];
                    carry_q[k] <= carry_d[k];
                    op_q[k]    <= op_d[k];
                    sat_q[k]   <= sat_d[k];
                    vld_q[k]   <= vld_d[k];
                end
            end
        end
    end

    always_comb begin
        logic cin_msb;
        logic [WIDTH-1:0] raw;
        raw = sum_q[LAST];
        // Carry into the MSB recovered from the MSB's own sum bit.
        cin_msb = raw[WIDTH-1] ^ a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1];
        V = cin_msb ^ carry_q[LAST];
        C = carry_q[LAST] ^ op_q[LAST];
        S = raw;
        if (sat_q[LAST] && V) begin
            S = a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        N = S[WIDTH-1];
        Z = vld_q[LAST] && (S == '0);
    end

endmodule

// File: tb/tb_pipelined_adder_subtractor.sv
// tb/tb_pipelined_adder_subtractor.sv - randomized self-checking bench against a reference model
module tb_pipelined_adder_subtractor;

    localparam int W = 16;
    localparam int K = 4;
    localparam int L = W / K;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A, B;
    logic         Op, Sat, in_valid, out_ready;
    logic         in_ready, out_valid;
    logic [W-1:0] S;
    logic         C, V, Z, N;

    always #5 clk = ~clk;

    pipelined_adder_subtractor #(.WIDTH(W), .CHUNK(K)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .Op(Op), .Sat(Sat),
        .in_valid(in_valid), .in_ready(in_ready),
        .S(S), .C(C), .V(V), .Z(Z), .N(N),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {
        logic [19:0] res;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   delivered = 0;
    bit   lat_chk = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Result packed as {S, C, V, Z, N}, derived from signed/unsigned integer arithmetic.
    function automatic logic [19:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic op, input logic sat);
        int          sa, sb, sr;
        logic [15:0] s;
        logic        c, v;
        sa = $signed(a);
        sb = $signed(b);
        sr = op ? sa - sb : sa + sb;
        v  = (sr > 32767) || (sr < -32768);
        c  = op ? (a < b) : ((32'(a) + 32'(b)) > 32'd65535);
        s  = sr[15:0];
        if (sat && v) s = a[15] ? 16'h8000 : 16'h7FFF;
        return {s, c, v, (s == 16'h0000), s[15]};
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Evaluate one cycle at its settled mid-point, then advance to the next falling edge.
    task automatic step();
        exp_t e;
        #1;
        if (in_valid && in_ready && !rst) q.push_back('{ref_model(A, B, Op, Sat), cyc});
        if (out_valid === 1'b1 && out_ready) begin
            if (q.size() == 0) begin
                check_eq("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check_eq("result", 32'({S, C, V, Z, N}), 32'(e.res));
                if (lat_chk) check_eq("latency", cyc - e.cyc, L);
                delivered++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic op, input logic sat);
        bit done;
        int n;
        A = a; B = b; Op = op; Sat = sat; in_valid = 1'b1;
        done = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            #1;
            done = in_ready;
            step();
            n++;
        end
        if (!done) check_eq("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        check_eq("drain_left", q.size(), 0);
    endtask

    initial begin
        int base;
        logic [15:0] vec_a [6] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h8000, 16'hFFFF, 16'h1234};
        logic [15:0] vec_b [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h1234};
        logic        vec_o [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        vec_s [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; A = '0; B = '0; Op = 1'b0; Sat = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        step();
        step();
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_outputs", 32'({S, C, V, Z, N}), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed corner vectors, back to back.
        lat_chk = 1'b1;
        for (int i = 0; i < 6; i++) send(vec_a[i], vec_b[i], vec_o[i], vec_s[i]);
        drain();

        // Stall: six back-to-back operations, then hold the output for three cycles.
        lat_chk = 1'b0;
        base = delivered;
        for (int i = 0; i < 6; i++) send(rnd16(), rnd16(), 1'($urandom), 1'($urandom));
        out_ready = 1'b0;
        A = 16'h1111; B = 16'h2222; Op = 1'b0; Sat = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_eq("stall_out_valid", 32'(out_valid), 32'd1);
            if (q.size() > 0) check_eq("stall_hold", 32'({S, C, V, Z, N}), 32'(q[0].res));
            else check_eq("stall_queue", q.size(), 1);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        check_eq("stall_count", delivered - base, 6);

        // Streaming: 32 random operations with the consumer always ready.
        lat_chk = 1'b1;
        for (int i = 0; i < 32; i++) send(rnd16(), rnd16(), 1'($urandom), 1'($urandom));
        drain();

        // Random backpressure and input gaps.
        lat_chk = 1'b0;
        for (int i = 0; i < 150; i++) begin
            in_valid = 1'($urandom);
            A = rnd16(); B = rnd16(); Op = 1'($urandom); Sat = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        out_ready = 1'b1;
        drain();

        // Reset with three operations in flight and a fourth presented during reset.
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) send(rnd16(), rnd16(), 1'($urandom), 1'($urandom));
        A = 16'h0F0F; B = 16'h0101; Op = 1'b0; Sat = 1'b0; in_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        q.delete();
        #1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_outputs", 32'({S, C, V, Z, N}), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq("midrst_quiet", 32'(out_valid), 32'd0);
            step();
        end
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
